// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//   Round-robin arbiter/sequencer placing two requesters (A and B) in front of
//   a single-port sram. Each requester issues one read or write at a time with
//   a req/gnt/ack handshake. Transactions are serialised (IDLE->ACCESS->WAIT),
//   out-of-range addresses are reported through x_err without touching the
//   sram, and the sram clear (sram_rst) is sequenced out of reset.
//
// Ports
//   clk                 clock, all state updates on posedge
//   rst                 asynchronous active-low reset
//   a_req/b_req         request, command held stable until gnt
//   a_wr/b_wr           1 = write, 0 = read
//   a_addr/b_addr       requester address (AW bits)
//   a_wdata/b_wdata     requester write data (DW bits)
//   a_gnt/b_gnt         1-cycle pulse, command captured
//   a_ack/b_ack         1-cycle pulse, transaction complete
//   a_err/b_err         valid with ack, 1 = address out of range
//   a_rdata/b_rdata     read data, updated on error-free read acks only
//   sram_we/sram_re     sram write/read strobes (one cycle each)
//   sram_addr/sram_data sram address / write data
//   sram_datao          sram registered read data
//   sram_rst            sram clear, active-high, released one edge after rst
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int AW    = 9,
    parameter int DW    = 9,
    parameter int DEPTH = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_wr,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_ack,
    output logic          a_err,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_wr,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_ack,
    output logic          b_err,
    output logic [DW-1:0] b_rdata,
    output logic          sram_we,
    output logic          sram_re,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_data,
    input  logic [DW-1:0] sram_datao,
    output logic          sram_rst
);

    // One extra bit so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0] LIMIT = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

    state_t        state, state_nxt;
    logic          ptr, ptr_nxt;          // 0: A wins a tie, 1: B wins a tie
    logic          own_b, own_b_nxt;      // owner of the in-flight transaction
    logic          cur_wr, cur_wr_nxt;
    logic          cur_err, cur_err_nxt;

    logic          a_gnt_nxt, b_gnt_nxt, a_ack_nxt, b_ack_nxt;
    logic          a_err_nxt, b_err_nxt;
    logic [DW-1:0] a_rdata_nxt, b_rdata_nxt;
    logic          we_nxt, re_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] data_nxt;

    logic          pick_b;
    logic          sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_bad;

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        own_b_nxt   = own_b;
        cur_wr_nxt  = cur_wr;
        cur_err_nxt = cur_err;
        a_gnt_nxt   = 1'b0;
        b_gnt_nxt   = 1'b0;
        a_ack_nxt   = 1'b0;
        b_ack_nxt   = 1'b0;
        a_err_nxt   = 1'b0;
        b_err_nxt   = 1'b0;
        a_rdata_nxt = a_rdata;
        b_rdata_nxt = b_rdata;
        we_nxt      = 1'b0;
        re_nxt      = 1'b0;
        addr_nxt    = sram_addr;
        data_nxt    = sram_data;

        // A lone requester wins regardless of the pointer; on a tie the
        // pointer decides.
        pick_b    = b_req & (~a_req | ptr);
        sel_wr    = pick_b ? b_wr    : a_wr;
        sel_addr  = pick_b ? b_addr  : a_addr;
        sel_wdata = pick_b ? b_wdata : a_wdata;
        sel_bad   = ({1'b0, sel_addr} >= LIMIT);

        unique case (state)
            IDLE: begin
                if (!sram_rst && (a_req || b_req)) begin
                    if (a_req && b_req) ptr_nxt = ~pick_b;
                    own_b_nxt   = pick_b;
                    a_gnt_nxt   = ~pick_b;
                    b_gnt_nxt   = pick_b;
                    cur_wr_nxt  = sel_wr;
                    cur_err_nxt = sel_bad;
                    if (!sel_bad) begin
                        we_nxt   = sel_wr;
                        re_nxt   = ~sel_wr;
                        addr_nxt = sel_addr;
                        data_nxt = sel_wdata;
                    end
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                state_nxt = IDLE;
                if (own_b) begin
                    b_ack_nxt = 1'b1;
                    b_err_nxt = cur_err;
                    if (!cur_wr && !cur_err) b_rdata_nxt = sram_datao;
                end else begin
                    a_ack_nxt = 1'b1;
                    a_err_nxt = cur_err;
                    if (!cur_wr && !cur_err) a_rdata_nxt = sram_datao;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            own_b     <= 1'b0;
            cur_wr    <= 1'b0;
            cur_err   <= 1'b0;
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_err     <= 1'b0;
            b_err     <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            sram_we   <= 1'b0;
            sram_re   <= 1'b0;
            sram_addr <= '0;
            sram_data <= '0;
            sram_rst  <= 1'b1;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            own_b     <= own_b_nxt;
            cur_wr    <= cur_wr_nxt;
            cur_err   <= cur_err_nxt;
            a_gnt     <= a_gnt_nxt;
            b_gnt     <= b_gnt_nxt;
            a_ack     <= a_ack_nxt;
            b_ack     <= b_ack_nxt;
            a_err     <= a_err_nxt;
            b_err     <= b_err_nxt;
            a_rdata   <= a_rdata_nxt;
            b_rdata   <= b_rdata_nxt;
            sram_we   <= we_nxt;
            sram_re   <= re_nxt;
            sram_addr <= addr_nxt;
            sram_data <= data_nxt;
            sram_rst  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
module tb_sram_arbiter;
    localparam int AW = 9;
    localparam int DW = 9;
    localparam int DEPTH = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_req = 1'b0, a_wr = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_req = 1'b0, b_wr = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          a_gnt, a_ack, a_err, b_gnt, b_ack, b_err;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          sram_we, sram_re, sram_rst;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_data;
    logic [DW-1:0] sram_datao = '0;

    always #5 clk = ~clk;

    sram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .sram_we(sram_we), .sram_re(sram_re), .sram_addr(sram_addr),
        .sram_data(sram_data), .sram_datao(sram_datao), .sram_rst(sram_rst)
    );

    // Behavioural single-port sram with registered read data and clear.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (sram_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            sram_datao <= '0;
        end else begin
            if (sram_we && int'(sram_addr) < DEPTH) mem[int'(sram_addr)] <= sram_data;
            if (sram_re && int'(sram_addr) < DEPTH) sram_datao <= mem[int'(sram_addr)];
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference model: edge-indexed timeline of transactions.
    int            ecount, next_free, ack_edge;
    bit            ack_pending, ack_b, ack_bad, ack_rdv;
    logic [DW-1:0] ack_rd;
    bit            mptr;                 // 0: A wins next tie
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_a_rdata, exp_b_rdata;
    logic          exp_a_gnt, exp_b_gnt, exp_a_ack, exp_b_ack;
    logic          exp_a_err, exp_b_err, exp_we, exp_re;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;

    function automatic void model_reset();
        ecount = 0;
        next_free = 2;
        ack_pending = 0;
        mptr = 0;
        exp_a_rdata = '0;
        exp_b_rdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endfunction

    // Advance one clock edge and compute the expected outputs for it.
    task automatic step();
        logic          sa, sb, wb, w;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        bit            bad;
        sa = a_req;
        sb = b_req;
        @(posedge clk);
        ecount++;
        exp_a_gnt = 0; exp_b_gnt = 0; exp_a_ack = 0; exp_b_ack = 0;
        exp_a_err = 0; exp_b_err = 0; exp_we = 0; exp_re = 0;
        if (ack_pending && ecount == ack_edge) begin
            ack_pending = 0;
            if (ack_b) begin
                exp_b_ack = 1; exp_b_err = ack_bad;
                if (ack_rdv) exp_b_rdata = ack_rd;
            end else begin
                exp_a_ack = 1; exp_a_err = ack_bad;
                if (ack_rdv) exp_a_rdata = ack_rd;
            end
        end
        if (ecount >= next_free && (sa || sb)) begin
            wb = (sa && sb) ? mptr : sb;
            if (sa && sb) mptr = !wb;
            w  = wb ? b_wr : a_wr;
            ad = wb ? b_addr : a_addr;
            wd = wb ? b_wdata : a_wdata;
            bad = (int'(ad) >= DEPTH);
            exp_a_gnt = !wb;
            exp_b_gnt = wb;
            exp_we = w && !bad;
            exp_re = !w && !bad;
            exp_addr = ad;
            exp_data = wd;
            ack_pending = 1; ack_edge = ecount + 2; ack_b = wb;
            ack_bad = bad; ack_rdv = !w && !bad;
            if (!bad) begin
                if (w) ref_mem[int'(ad)] = wd;
                else   ack_rd = ref_mem[int'(ad)];
            end
            next_free = ecount + 3;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({a_gnt, b_gnt, a_ack, b_ack, a_err, b_err, sram_we, sram_re, sram_rst} !== 9'b000000001) begin
            errors++;
            $display("FAIL reset_ctl got %b want 000000001", {a_gnt, b_gnt, a_ack, b_ack, a_err, b_err, sram_we, sram_re, sram_rst});
        end
        checks++;
        if ({a_rdata, b_rdata, sram_addr, sram_data} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h want 0", a_rdata, b_rdata, sram_addr, sram_data);
        end
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (sram_rst !== 1'b1) begin
            errors++; $display("FAIL reset_release_sram_rst got %b want 1", sram_rst);
        end
        @(negedge clk);
        step();
        checks++;
        if ({sram_rst, a_gnt, b_gnt} !== 3'b000) begin
            errors++; $display("FAIL reset_first_edge got %b want 000", {sram_rst, a_gnt, b_gnt});
        end
    endtask

    task automatic test_write_read();
        int  phase = 0;
        int  gnt_at = 0;
        bit  got = 0;
        a_req = 1; a_wr = 1; a_addr = 9'd3; a_wdata = 9'h1A5;
        for (int c = 0; c < 12; c++) begin
            step();
            checks++;
            if ({a_gnt, b_gnt, a_ack, b_ack} !== {exp_a_gnt, exp_b_gnt, exp_a_ack, exp_b_ack}) begin
                errors++; $display("FAIL wr_rd_hs e=%0d got %b want %b", ecount, {a_gnt, b_gnt, a_ack, b_ack}, {exp_a_gnt, exp_b_gnt, exp_a_ack, exp_b_ack});
            end
            checks++;
            if ({sram_we, sram_re} !== {exp_we, exp_re} || ((exp_we || exp_re) && sram_addr !== exp_addr)) begin
                errors++; $display("FAIL wr_rd_strobe e=%0d got %b/%h want %b/%h", ecount, {sram_we, sram_re}, sram_addr, {exp_we, exp_re}, exp_addr);
            end
            if (a_ack && phase == 2) begin
                got = 1;
                checks++;
                if (ecount - gnt_at != 2 || a_rdata !== 9'h1A5 || a_err !== 1'b0) begin
                    errors++; $display("FAIL wr_rd_result lat=%0d rdata=%h err=%b want lat=2 rdata=1a5 err=0", ecount - gnt_at, a_rdata, a_err);
                end
            end
            if (a_gnt) begin
                gnt_at = ecount;
                if (phase == 0) begin a_wr = 0; a_wdata = '0; phase = 1; end
                else begin a_req = 0; phase = 2; end
            end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL wr_rd_timeout got no read ack want ack"); end
    endtask

    task automatic test_contention();
        bit order [$];
        apply_reset();
        a_req = 1; a_wr = 0; a_addr = 9'd1;
        b_req = 1; b_wr = 0; b_addr = 9'd2;
        for (int c = 0; c < 14; c++) begin
            step();
            checks++;
            if ({a_gnt, b_gnt, a_ack, b_ack} !== {exp_a_gnt, exp_b_gnt, exp_a_ack, exp_b_ack}) begin
                errors++; $display("FAIL rr_hs e=%0d got %b want %b", ecount, {a_gnt, b_gnt, a_ack, b_ack}, {exp_a_gnt, exp_b_gnt, exp_a_ack, exp_b_ack});
            end
            if (a_gnt) order.push_back(1'b0);
            if (b_gnt) order.push_back(1'b1);
            if (c == 10) begin a_req = 0; b_req = 0; end
        end
        checks++;
        if (order.size() != 4 || order[0] !== 1'b0 || order[1] !== 1'b1 || order[2] !== 1'b0 || order[3] !== 1'b1) begin
            errors++; $display("FAIL rr_order got %0d grants %p want A,B,A,B", order.size(), order);
        end
    endtask

    task automatic test_error();
        int  gnt_at = -100;
        bit  got = 0;
        b_req = 1; b_wr = 0; b_addr = 9'd9;
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if ({sram_we, sram_re} !== 2'b00) begin
                errors++; $display("FAIL err_strobe e=%0d got %b want 00", ecount, {sram_we, sram_re});
            end
            checks++;
            if ({a_gnt, b_gnt, a_ack, b_ack} !== {exp_a_gnt, exp_b_gnt, exp_a_ack, exp_b_ack} || b_rdata !== exp_b_rdata) begin
                errors++; $display("FAIL err_hs e=%0d got %b/%h want %b/%h", ecount, {a_gnt, b_gnt, a_ack, b_ack}, b_rdata, {exp_a_gnt, exp_b_gnt, exp_a_ack, exp_b_ack}, exp_b_rdata);
            end
            if (b_ack) begin
                got = 1;
                checks++;
                if (b_err !== 1'b1 || ecount - gnt_at != 2) begin
                    errors++; $display("FAIL err_flag got err=%b lat=%0d want err=1 lat=2", b_err, ecount - gnt_at);
                end
            end
            if (b_gnt) begin gnt_at = ecount; b_req = 0; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL err_timeout got no b_ack want ack"); end
    endtask

    task automatic test_mid_reset();
        bit seen = 0;
        a_req = 1; a_wr = 1; a_addr = 9'd4; a_wdata = 9'h0AB;
        for (int c = 0; c < 6 && !seen; c++) begin
            step();
            if (a_gnt) seen = 1;
        end
        checks++;
        if (!seen || sram_we !== 1'b1) begin
            errors++; $display("FAIL midrst_setup got gnt=%b we=%b want 1 1", a_gnt, sram_we);
        end
        rst = 1'b0;
        a_req = 0;
        #1;
        checks++;
        if ({a_gnt, b_gnt, a_ack, b_ack, sram_we, sram_re, sram_rst} !== 7'b0000001) begin
            errors++; $display("FAIL midrst_async got %b want 0000001", {a_gnt, b_gnt, a_ack, b_ack, sram_we, sram_re, sram_rst});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({a_ack, b_ack, a_gnt, sram_we} !== 4'b0000) begin
                errors++; $display("FAIL midrst_hold got %b want 0000", {a_ack, b_ack, a_gnt, sram_we});
            end
        end
        rst = 1'b1;
        model_reset();
        b_req = 1; b_wr = 0; b_addr = 9'd4;
        step();
        checks++;
        if ({b_gnt, sram_rst} !== 2'b00) begin
            errors++; $display("FAIL midrst_edge1 got %b want 00", {b_gnt, sram_rst});
        end
        step();
        checks++;
        if ({a_gnt, b_gnt} !== 2'b01 || b_gnt !== exp_b_gnt) begin
            errors++; $display("FAIL midrst_bgrant got %b want 01", {a_gnt, b_gnt});
        end
        b_req = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({a_ack, b_ack, a_err, b_err} !== {exp_a_ack, exp_b_ack, exp_a_err, exp_b_err} || b_rdata !== exp_b_rdata) begin
                errors++; $display("FAIL midrst_ack e=%0d got %b/%h want %b/%h", ecount, {a_ack, b_ack, a_err, b_err}, b_rdata, {exp_a_ack, exp_b_ack, exp_a_err, exp_b_err}, exp_b_rdata);
            end
        end
    endtask

    task automatic test_interleave();
        int            ai = 0, bi = 0, ngr = 0;
        bit            last = 0;
        logic [AW-1:0] bq [$];
        logic [DW-1:0] ev;
        apply_reset();
        a_req = 1; a_wr = 1; a_addr = '0; a_wdata = 9'h155;
        b_req = 1; b_wr = 0; b_addr = '0;
        for (int c = 0; c < 80 && (ai < 9 || bi < 9 || bq.size() != 0); c++) begin
            step();
            checks++;
            if ({a_gnt, b_gnt, a_ack, b_ack} !== {exp_a_gnt, exp_b_gnt, exp_a_ack, exp_b_ack}) begin
                errors++; $display("FAIL ilv_hs e=%0d got %b want %b", ecount, {a_gnt, b_gnt, a_ack, b_ack}, {exp_a_gnt, exp_b_gnt, exp_a_ack, exp_b_ack});
            end
            checks++;
            if ((sram_we && sram_re) || {sram_we, sram_re} !== {exp_we, exp_re}) begin
                errors++; $display("FAIL ilv_strobe e=%0d got %b want %b", ecount, {sram_we, sram_re}, {exp_we, exp_re});
            end
            if (b_ack) begin
                ev = '0;
                if (bq.size() != 0) ev = bq.pop_front() ^ 9'h155;
                checks++;
                if (b_rdata !== ev || b_rdata !== exp_b_rdata) begin
                    errors++; $display("FAIL ilv_rdata got %h want %h", b_rdata, ev);
                end
            end
            if (a_gnt || b_gnt) begin
                if (ngr > 0) begin
                    checks++;
                    if (b_gnt == last) begin
                        errors++; $display("FAIL ilv_alternate grant %0d got %s twice want alternation", ngr, b_gnt ? "B" : "A");
                    end
                end
                last = b_gnt;
                ngr++;
            end
            if (a_gnt) begin
                ai++;
                if (ai < 9) begin a_addr = AW'(ai); a_wdata = DW'(ai) ^ 9'h155; end
                else a_req = 0;
            end
            if (b_gnt) begin
                bq.push_back(b_addr);
                bi++;
                if (bi < 9) b_addr = AW'(bi);
                else b_req = 0;
            end
        end
        checks++;
        if (ai != 9 || bi != 9 || bq.size() != 0) begin
            errors++; $display("FAIL ilv_timeout got a=%0d b=%0d pend=%0d want 9 9 0", ai, bi, bq.size());
        end
    endtask

    task automatic test_release_grant();
        rst = 1'b0;
        a_req = 0; b_req = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        a_req = 1; a_wr = 0; a_addr = 9'd5;
        #1;
        checks++;
        if ({sram_rst, a_gnt} !== 2'b10) begin
            errors++; $display("FAIL rel_pre got %b want 10", {sram_rst, a_gnt});
        end
        step();
        checks++;
        if ({sram_rst, a_gnt} !== 2'b00) begin
            errors++; $display("FAIL rel_edge1 got %b want 00", {sram_rst, a_gnt});
        end
        step();
        checks++;
        if (a_gnt !== 1'b1 || a_gnt !== exp_a_gnt) begin
            errors++; $display("FAIL rel_edge2 got gnt=%b want 1", a_gnt);
        end
        a_req = 0;
        repeat (3) step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (a_gnt || !a_req) begin
                a_req = 1'($urandom_range(0, 1)); a_wr = 1'($urandom_range(0, 1));
                a_addr = AW'($urandom_range(0, 11)); a_wdata = DW'($urandom);
            end
            if (b_gnt || !b_req) begin
                b_req = 1'($urandom_range(0, 1)); b_wr = 1'($urandom_range(0, 1));
                b_addr = AW'($urandom_range(0, 11)); b_wdata = DW'($urandom);
            end
            if (c >= 395) begin a_req = 0; b_req = 0; end
            step();
            checks++;
            if ({a_gnt, b_gnt, a_ack, b_ack} !== {exp_a_gnt, exp_b_gnt, exp_a_ack, exp_b_ack}) begin
                errors++; $display("FAIL rnd_hs e=%0d got %b want %b", ecount, {a_gnt, b_gnt, a_ack, b_ack}, {exp_a_gnt, exp_b_gnt, exp_a_ack, exp_b_ack});
            end
            checks++;
            if ({sram_we, sram_re} !== {exp_we, exp_re} ||
                ((exp_we || exp_re) && sram_addr !== exp_addr) || (exp_we && sram_data !== exp_data)) begin
                errors++; $display("FAIL rnd_strobe e=%0d got %b/%h/%h want %b/%h/%h", ecount, {sram_we, sram_re}, sram_addr, sram_data, {exp_we, exp_re}, exp_addr, exp_data);
            end
            checks++;
            if ({a_ack & a_err, b_ack & b_err} !== {exp_a_err, exp_b_err}) begin
                errors++; $display("FAIL rnd_err e=%0d got %b want %b", ecount, {a_ack & a_err, b_ack & b_err}, {exp_a_err, exp_b_err});
            end
            checks++;
            if (a_rdata !== exp_a_rdata || b_rdata !== exp_b_rdata) begin
                errors++; $display("FAIL rnd_rdata e=%0d got %h/%h want %h/%h", ecount, a_rdata, b_rdata, exp_a_rdata, exp_b_rdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_error();
        test_mid_reset();
        test_interleave();
        test_release_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
